aes_block_loader: RTL and testbench
===================================

# aes_block_loader

Byte-serial front end for the AES datapath. Receives a framed byte stream (header, key, plaintext) over a valid/ready handshake and assembles one complete block: mode, round count, left-aligned key and 128-bit plaintext. It presents that block on a parallel valid/ready port to the cipher/decipher cores. It is the writer side of the block interface that the self-checking top level reads.

## Interface
Parameters:
- `KEY_W`, 256: width of the key output bus; must be 256.
- `TXT_W`, 128: plaintext width; must be 128.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `flush`  in  1  synchronous abort; returns to IDLE and discards the partial frame.
- `in_byte`  in  8  stream byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `blk_valid`  out  1  assembled block is available.
- `blk_ready`  in  1  consumer takes the block.
- `blk_mode`  out  2  key size: 00 = 128, 01 = 192, 10 = 256.
- `blk_nr`  out  4  round count: 10, 12 or 14.
- `blk_key`  out  256  key, MSB-first and left-aligned; unused low bits are 0.
- `blk_text`  out  128  plaintext, MSB-first.
- `err`  out  1  one-cycle pulse on a rejected header.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- A byte transfers when `in_valid && in_ready`. A block transfers when `blk_valid && blk_ready`.
- States are IDLE, KEY, DATA and OUT. `in_ready` is 1 in IDLE, KEY and DATA, and 0 in OUT.
- IDLE, header byte accepted:
  - Bits [1:0] select the mode.
  - Mode 11 pulses `err`, stays in IDLE and discards the byte.
  - Otherwise the loader latches the mode, clears the key register and byte counter, and goes to KEY.
  - Header bits [7:2] are ignored, except bit 2 when the configuration macro is compiled in.
- KEY: each accepted byte is written to `key[255-8*cnt -: 8]`, then `cnt` increments.
  - After key byte 16, 24 or 32 (mode 00, 01, 10), clear `cnt` and go to DATA.
- DATA: each accepted byte is written to `text[127-8*cnt -: 8]`.
  - After byte 16, go to OUT.
- OUT: `blk_valid` = 1. All `blk_*` outputs hold stable until the block transfers, then go to IDLE.
- `blk_nr` is decoded from the latched mode: 10, 12 or 14.
- `flush` has priority over every transfer in the same cycle. It clears `cnt` and the state only; the key and text registers keep their contents.
- `rst` asserted in mid-frame: all state clears immediately and the partial frame is lost.
- `in_valid` while `in_ready` = 0 is legal; the byte must be held by the source.

## Timing
- Reset values:
  - state = IDLE; `in_ready` = 1; `blk_valid` = 0.
  - `blk_mode` = 0, `blk_nr` = 10, `blk_key` = 0, `blk_text` = 0.
  - `err` = 0, `busy` = 0.
- Last plaintext byte accepted at edge N gives `blk_valid` = 1 from cycle N+1.
- Block transfer at edge M gives `in_ready` = 1 from cycle M+1. There is no header/output overlap.
- Minimum frame-to-frame period is 1 + Nk·4 + 16 + 1 cycles, where Nk is 4, 6 or 8 (34, 42 or 50 cycles).
- `err` asserts in the cycle after the rejected header and lasts exactly one cycle.
- Registered outputs only; there is no combinational path from `in_*` to `blk_*`.

## Configuration
- `AES_LOADER_KEY_REUSE_EN` defined:
  - Header bit 2 = 1 skips KEY: the loader goes directly to DATA and keeps the previous key and mode; header bits [1:0] are ignored.
  - A `key_loaded` flag is set when a key completes and cleared by `rst`. Reuse while `key_loaded` = 0 pulses `err` and stays in IDLE.
  - Because reuse skips the key-register clear, a `flush` during KEY leaves a partial key: clear `key_loaded` on `flush` from KEY.
- Undefined: bit 2 is ignored, every frame carries a key, and there is no `key_loaded` logic.

## Structure
- Shared package `aes_pkg` holds:
  - mode encodings `AES_128`, `AES_192` and `AES_256`;
  - constants `NR_128` = 10, `NR_192` = 12, `NR_256` = 14;
  - key byte counts 16, 24 and 32;
  - the loader state typedef.
- A single module. The mode-to-Nr/key-length decode is a package function, not a sub-module.

## Test plan
- 128-bit frame: header 00, key 00 01 … 0f, text 00 11 … ff, with `blk_ready` = 1. Expect:
  - `blk_key` = 000102…0f followed by 128 zero bits;
  - `blk_text` = 00112233…eeff;
  - `blk_nr` = 10;
  - `blk_valid` exactly 1 cycle after the 33rd byte.
- 256-bit frame: key 00 … 1f, and `blk_ready` held low for 5 cycles. Expect:
  - outputs stable across the stall, `blk_nr` = 14, `in_ready` = 0 throughout;
  - IDLE one cycle after the release.
- Header 03. Expect `err` high for exactly 1 cycle, `busy` = 0, and the next header 01 accepted normally with `blk_nr` = 12.
- `flush` after 10 key bytes, in the same cycle as `in_valid`. Expect the byte not stored, IDLE next cycle, and a following full 192-bit frame correct.
- `rst` pulsed during DATA byte 7. Expect all outputs at reset values immediately and no `blk_valid` for that frame.
- With `AES_LOADER_KEY_REUSE_EN`:
  - header 04 straight after reset gives `err`;
  - after one 128-bit frame, header 04 plus 16 text bytes gives the same `blk_key` and `blk_valid` 17 cycles after the header.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: mode encodings, round counts,
// key byte counts and the block-loader state type.
package aes_pkg;

   localparam logic [1:0] AES_128 = 2'b00;
   localparam logic [1:0] AES_192 = 2'b01;
   localparam logic [1:0] AES_256 = 2'b10;
   localparam logic [1:0] AES_BAD = 2'b11;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   localparam int KB_128 = 16;
   localparam int KB_192 = 24;
   localparam int KB_256 = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_KEY,
      ST_DATA,
      ST_OUT
   } ld_state_t;

   function automatic logic [3:0] nr_of(input logic [1:0] m);
      case (m)
         AES_192: return NR_192;
         AES_256: return NR_256;
         default: return NR_128;
      endcase
   endfunction

   // Index of the final key byte for a mode.
   function automatic logic [4:0] key_last(input logic [1:0] m);
      case (m)
         AES_192: return 5'(KB_192 - 1);
         AES_256: return 5'(KB_256 - 1);
         default: return 5'(KB_128 - 1);
      endcase
   endfunction

endpackage

// File: rtl/aes_block_loader.sv
// Byte-serial loader: header, key, plaintext -> one AES block.
// Optional AES_LOADER_KEY_REUSE_EN: header bit 2 reuses the last key.
module aes_block_loader
   import aes_pkg::*;
#(
   parameter int KEY_W = 256,
   parameter int TXT_W = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [7:0]       in_byte,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic [1:0]       blk_mode,
   output logic [3:0]       blk_nr,
   output logic [KEY_W-1:0] blk_key,
   output logic [TXT_W-1:0] blk_text,
   output logic             err,
   output logic             busy
);

   ld_state_t        state;
   logic [1:0]       mode_q;
   logic [4:0]       cnt;
   logic [KEY_W-1:0] key_q;
   logic [TXT_W-1:0] text_q;
   logic             err_q;
   logic             take;
   logic [7:0]       kidx;
   logic [6:0]       tidx;

`ifdef AES_LOADER_KEY_REUSE_EN
   logic key_loaded;
`endif

   assign take = in_valid && in_ready;
   assign kidx = 8'd255 - {cnt, 3'b000};
   assign tidx = 7'd127 - {cnt[3:0], 3'b000};

   // Frame sequencer: header decode, key/text fill, block hand-off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         mode_q <= AES_128;
         cnt    <= '0;
         key_q  <= '0;
         text_q <= '0;
         err_q  <= 1'b0;
`ifdef AES_LOADER_KEY_REUSE_EN
         key_loaded <= 1'b0;
`endif
      end else begin
         err_q <= 1'b0;
         if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
`ifdef AES_LOADER_KEY_REUSE_EN
            // Key register now holds a partial key.
            if (state == ST_KEY) key_loaded <= 1'b0;
`endif
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (take) begin
`ifdef AES_LOADER_KEY_REUSE_EN
                     if (in_byte[2]) begin
                        if (key_loaded) begin
                           cnt   <= '0;
                           state <= ST_DATA;
                        end else begin
                           err_q <= 1'b1;
                        end
                     end else
`endif
                     if (in_byte[1:0] == AES_BAD) begin
                        err_q <= 1'b1;
                     end else begin
                        mode_q <= in_byte[1:0];
                        key_q  <= '0;
                        cnt    <= '0;
                        state  <= ST_KEY;
                     end
                  end
               end
               ST_KEY: begin
                  if (take) begin
                     key_q[kidx -: 8] <= in_byte;
                     if (cnt == key_last(mode_q)) begin
                        cnt   <= '0;
                        state <= ST_DATA;
`ifdef AES_LOADER_KEY_REUSE_EN
                        key_loaded <= 1'b1;
`endif
                     end else begin
                        cnt <= cnt + 5'd1;
                     end
                  end
               end
               ST_DATA: begin
                  if (take) begin
                     text_q[tidx -: 8] <= in_byte;
                     if (cnt == 5'd15) begin
                        cnt   <= '0;
                        state <= ST_OUT;
                     end else begin
                        cnt <= cnt + 5'd1;
                     end
                  end
               end
               ST_OUT: begin
                  if (blk_ready) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign in_ready  = (state != ST_OUT);
   assign blk_valid = (state == ST_OUT);
   assign busy      = (state != ST_IDLE);
   assign blk_mode  = mode_q;
   assign blk_nr    = nr_of(mode_q);
   assign blk_key   = key_q;
   assign blk_text  = text_q;
   assign err       = err_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: directed frames
// plus randomized frames against a queue-based block model.
module tb_aes_block_loader;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic [7:0]   in_byte = 8'h00;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         blk_valid;
   logic         blk_ready = 1'b1;
   logic [1:0]   blk_mode;
   logic [3:0]   blk_nr;
   logic [255:0] blk_key;
   logic [127:0] blk_text;
   logic         err;
   logic         busy;

   aes_block_loader #(.KEY_W(256), .TXT_W(128)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_byte(in_byte), .in_valid(in_valid),
      .in_ready(in_ready), .blk_valid(blk_valid),
      .blk_ready(blk_ready), .blk_mode(blk_mode),
      .blk_nr(blk_nr), .blk_key(blk_key),
      .blk_text(blk_text), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   mode;
      logic [3:0]   nr;
      logic [255:0] key;
      logic [127:0] text;
   } blk_t;

   blk_t         q[$];
   int           n_chk = 0;
   int           n_fail = 0;
   int           cyc = 0;
   bit           rand_ready = 1'b0;
   logic [255:0] last_key = '0;
   logic [1:0]   last_mode = 2'b00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int kbytes(input logic [1:0] m);
      return 16 + 8 * int'(m);
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
      in_byte = b;
      in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 300) begin
            chk("in_ready_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [1:0] m, input bit pat,
                             input bit push, input int maxgap);
      blk_t       b;
      logic [7:0] kb[32];
      logic [7:0] tx[16];
      logic [7:0] hdr;
      logic [7:0] r;
      b.key = '0;
      b.text = '0;
      for (int i = 0; i < kbytes(m); i++) begin
         kb[i] = pat ? 8'(i) : 8'($urandom);
         b.key[255 - 8*i -: 8] = kb[i];
      end
      for (int i = 0; i < 16; i++) begin
         tx[i] = pat ? 8'(i * 17) : 8'($urandom);
         b.text[127 - 8*i -: 8] = tx[i];
      end
      b.mode = m;
      b.nr = 4'(10 + 2 * int'(m));
      r = 8'($urandom);
`ifdef AES_LOADER_KEY_REUSE_EN
      r[2] = 1'b0;
`endif
      hdr = pat ? {6'b0, m} : {r[7:2], m};
      if (push) q.push_back(b);
      last_key = b.key;
      last_mode = m;
      send_byte(hdr, $urandom_range(0, maxgap));
      for (int i = 0; i < kbytes(m); i++)
         send_byte(kb[i], $urandom_range(0, maxgap));
      for (int i = 0; i < 16; i++)
         send_byte(tx[i], $urandom_range(0, maxgap));
   endtask

   // Compare every presented block against the model queue.
   always @(negedge clk) begin
      if (!rst && blk_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_blk_valid", blk_valid, 0);
         end else begin
            chk("blk_mode", blk_mode, q[0].mode);
            chk("blk_nr", blk_nr, q[0].nr);
            chk("blk_key", blk_key, q[0].key);
            chk("blk_text", blk_text, q[0].text);
            chk("in_ready_in_out", in_ready, 0);
            chk("busy_in_out", busy, 1);
            if (blk_ready) void'(q.pop_front());
         end
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (rand_ready) blk_ready = 1'($urandom_range(0, 1));
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_blk_valid"}, blk_valid, 0);
      chk({tag, "_blk_mode"}, blk_mode, 0);
      chk({tag, "_blk_nr"}, blk_nr, 10);
      chk({tag, "_blk_key"}, blk_key, 0);
      chk({tag, "_blk_text"}, blk_text, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [255:0] part;
      blk_t         b;
      int           h;

      repeat (2) @(posedge clk);
      #1 chk_reset_vals("rst_hold");
      rst = 1'b0;
      @(posedge clk);
      #1 chk_reset_vals("rst_rel");

`ifdef AES_LOADER_KEY_REUSE_EN
      send_byte(8'h04, 0);
      chk("reuse_no_key_err", err, 1);
      chk("reuse_no_key_busy", busy, 0);
      send_frame(2'b00, 1'b1, 1'b1, 0);
      @(posedge clk);
      #1;
      b.key = last_key;
      b.mode = last_mode;
      b.nr = 4'd10;
      b.text = {$urandom, $urandom, $urandom, $urandom};
      q.push_back(b);
      send_byte(8'h04, 0);
      h = cyc;
      for (int i = 0; i < 16; i++)
         send_byte(b.text[127 - 8*i -: 8], 0);
      chk("reuse_latency", cyc - h, 16);
      chk("reuse_valid", blk_valid, 1);
      chk("reuse_key", blk_key,
          256'h000102030405060708090a0b0c0d0e0f << 128);
      @(posedge clk);
      #1;
`endif

      // 128-bit frame, consumer always ready.
      send_frame(2'b00, 1'b1, 1'b1, 0);
      chk("f128_valid", blk_valid, 1);
      chk("f128_key", blk_key,
          256'h000102030405060708090a0b0c0d0e0f << 128);
      chk("f128_text", blk_text,
          128'h00112233445566778899aabbccddeeff);
      chk("f128_nr", blk_nr, 10);
      @(posedge clk);
      #1 chk("f128_idle", busy, 0);

      // 256-bit frame, consumer stalls 5 cycles.
      blk_ready = 1'b0;
      send_frame(2'b10, 1'b1, 1'b1, 0);
      for (int i = 0; i < 5; i++) begin
         chk("f256_valid", blk_valid, 1);
         chk("f256_in_ready", in_ready, 0);
         chk("f256_nr", blk_nr, 14);
         chk("f256_key", blk_key, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
         @(posedge clk);
         #1;
      end
      blk_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("f256_rel_busy", busy, 0);
      chk("f256_rel_in_ready", in_ready, 1);
      chk("f256_rel_valid", blk_valid, 0);

      // Rejected header, then a normal 192-bit header.
      send_byte(8'h03, 0);
      chk("hdr03_err", err, 1);
      chk("hdr03_busy", busy, 0);
      @(posedge clk);
      #1 chk("hdr03_err_one", err, 0);
      send_frame(2'b01, 1'b1, 1'b1, 0);
      chk("after_err_nr", blk_nr, 12);
      @(posedge clk);
      #1;

      // Flush after 10 key bytes, with a byte offered.
      send_byte(8'h01, 0);
      part = '0;
      for (int i = 0; i < 10; i++) begin
         send_byte(8'(8'ha0 + i), 0);
         part[255 - 8*i -: 8] = 8'(8'ha0 + i);
      end
      in_byte = 8'h5a;
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_busy", busy, 0);
      chk("flush_in_ready", in_ready, 1);
      chk("flush_key_kept", blk_key, part);
      send_frame(2'b01, 1'b0, 1'b1, 1);
      @(posedge clk);
      #1;

      // Reset during DATA byte 7.
      send_byte(8'h00, 0);
      for (int i = 0; i < 16; i++) send_byte(8'hc3, 0);
      for (int i = 0; i < 6; i++) send_byte(8'h3c, 0);
      in_byte = 8'haa;
      in_valid = 1'b1;
      #2 rst = 1'b1;
      #1 chk_reset_vals("mid_rst");
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (40) @(posedge clk);
      #1 chk("mid_rst_no_blk", blk_valid, 0);
`ifdef AES_LOADER_KEY_REUSE_EN
      send_byte(8'h04, 0);
      chk("reuse_after_rst_err", err, 1);
`endif

      // Randomized frames with random consumer back-pressure.
      rand_ready = 1'b1;
      for (int f = 0; f < 24; f++) begin
         if ($urandom_range(0, 5) == 0) begin
            h = int'($urandom) & 32'hf8;
            send_byte(8'(h) | 8'h03, $urandom_range(0, 2));
            chk("rand_bad_hdr_err", err, 1);
         end else begin
            send_frame(2'($urandom_range(0, 2)), 1'b0, 1'b1, 2);
         end
      end
      @(posedge clk);
      #1 rand_ready = 1'b0;
      @(posedge clk);
      #1 blk_ready = 1'b1;
      for (int i = 0; i < 200 && q.size() != 0; i++)
         @(posedge clk);
      #1 chk("queue_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
